// File: rtl/osd_cmd_feeder.sv
// osd_cmd_feeder: pairs MCU bytes into 16-bit OSD command words, queues them,
// and presents each word on osd_command for a minimum hold time. Repeated
// identical words are split by a 0x0000 no-op so the overlay sees a change.
module osd_cmd_feeder #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned FIFO_AW     = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_strobe,
  input  logic        rx_frame,
  output logic [15:0] osd_command,
  output logic        fifo_full,
  output logic        busy,
  output logic        overflow
);

  localparam int unsigned WORD_W = 16;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned DEPTH  = 1 << FIFO_AW;
  localparam int unsigned FCNT_W = FIFO_AW + 1;

  // Word hold reload; the extra IDLE cycle after HOLD supplies the final clock.
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  // The separator hands straight over to HOLD with no IDLE cycle in between,
  // so it counts one further to stay on screen as long as a normal word.
  localparam logic [CNT_W-1:0] SEP_LOAD  = CNT_W'(HOLD_CYCLES);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEP  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  // ---------------------------------------------------------------------------
  // Byte pair assembly
  // ---------------------------------------------------------------------------
  logic       ph;
  logic [7:0] hi_byte;
  logic       frame_q;
  logic       frame_fall_c;
  logic       strobe_ok_c;
  logic       push_c;

  assign frame_fall_c = frame_q & ~rx_frame;
  assign strobe_ok_c  = rx_strobe & rx_frame;
  assign push_c       = strobe_ok_c & ph;

  // Phase tracking: first byte of a pair is the command, second completes it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ph      <= 1'b0;
      hi_byte <= 8'h00;
      frame_q <= 1'b0;
    end else begin
      frame_q <= rx_frame;
      if (frame_fall_c) begin
        ph <= 1'b0;
      end else if (strobe_ok_c) begin
        if (!ph) begin
          hi_byte <= rx_data;
        end
        ph <= ~ph;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------------
  logic [WORD_W-1:0]  mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FCNT_W-1:0]  count;
  logic [FCNT_W-1:0]  count_nxt;
  logic               full_c;
  logic               empty_c;
  logic               wr_en_c;
  logic               drop_c;
  logic               pop_c;
  logic [WORD_W-1:0]  head_c;

  assign full_c  = (count == FCNT_W'(DEPTH));
  assign empty_c = (count == '0);
  assign wr_en_c = push_c & ~full_c;
  assign drop_c  = push_c & full_c;
  assign head_c  = mem[rd_ptr];

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      mem[wr_ptr] <= {hi_byte, rx_data};
    end
  end

  // Occupancy after this cycle's push and pop.
  always_comb begin
    count_nxt = count;
    if (wr_en_c && !pop_c) begin
      count_nxt = count + FCNT_W'(1);
    end else if (!wr_en_c && pop_c) begin
      count_nxt = count - FCNT_W'(1);
    end
  end

  // Pointers, occupancy and the status flags derived from them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      fifo_full <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (wr_en_c) begin
        wr_ptr <= wr_ptr + FIFO_AW'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + FIFO_AW'(1);
      end
      count     <= count_nxt;
      fifo_full <= (count_nxt == FCNT_W'(DEPTH));
      if (drop_c) begin
        overflow <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output FSM
  // ---------------------------------------------------------------------------
  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [WORD_W-1:0] pend;
  logic [WORD_W-1:0] pend_nxt;
  logic [WORD_W-1:0] cmd_nxt;

  // State, hold counter, pending word and the registered command output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      pend        <= '0;
      osd_command <= '0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      pend        <= pend_nxt;
      osd_command <= cmd_nxt;
    end
  end

  // Next-state: pop in IDLE, insert a separator for repeats, count down holds.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pend_nxt  = pend;
    cmd_nxt   = osd_command;
    pop_c     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!empty_c) begin
          pop_c = 1'b1;
          if (head_c != osd_command) begin
            cmd_nxt   = head_c;
            cnt_nxt   = HOLD_LOAD;
            state_nxt = ST_HOLD;
          end else if (head_c != '0) begin
            cmd_nxt   = '0;
            pend_nxt  = head_c;
            cnt_nxt   = SEP_LOAD;
            state_nxt = ST_SEP;
          end
        end
      end
      ST_SEP: begin
        if (cnt == '0) begin
          cmd_nxt   = pend;
          cnt_nxt   = HOLD_LOAD;
          state_nxt = ST_HOLD;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (cnt == '0) begin
          state_nxt = ST_IDLE;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Busy while anything is queued or a word/separator is still being held.
  assign busy = ~empty_c | (state != ST_IDLE);

endmodule

// File: tb/tb_osd_cmd_feeder.sv
// Bench for osd_cmd_feeder: two instances (HOLD 4 / depth 16 and HOLD 255 /
// depth 4) share one stimulus stream; a timeline model predicts both outputs.
module tb_osd_cmd_feeder;

  logic        clk;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_strobe;
  logic        rx_frame;
  logic [15:0] osd_a, osd_b;
  logic        full_a, full_b, busy_a, busy_b, ovf_a, ovf_b;

  osd_cmd_feeder #(.HOLD_CYCLES(4), .FIFO_AW(4)) dut_a (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_strobe(rx_strobe),
    .rx_frame(rx_frame), .osd_command(osd_a), .fifo_full(full_a),
    .busy(busy_a), .overflow(ovf_a)
  );

  osd_cmd_feeder #(.HOLD_CYCLES(255), .FIFO_AW(2)) dut_b (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_strobe(rx_strobe),
    .rx_frame(rx_frame), .osd_command(osd_b), .fifo_full(full_b),
    .busy(busy_b), .overflow(ovf_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  function automatic int hold_of(input int i);
    return (i == 0) ? 4 : 255;
  endfunction

  function automatic int depth_of(input int i);
    return (i == 0) ? 16 : 4;
  endfunction

  // ---------------------------------------------------------------------------
  // Model: a queue of words and, per instance, the value on screen plus the
  // number of edges before it may change. A repeat expands into 0x0000, word.
  // ---------------------------------------------------------------------------
  logic [15:0] m_q [2][16];
  int          m_n   [2];
  logic [15:0] m_cur [2];
  int          m_rem [2];
  logic        m_pv  [2];
  logic [15:0] m_pend[2];
  logic        m_ov  [2];
  logic        m_ph, m_frame_q, m_dopush;
  logic [7:0]  m_hi;
  logic [15:0] m_pw, m_w;
  int          m_pre;

  always begin
    @(posedge clk or posedge reset);
    if (reset) begin
      m_ph = 1'b0; m_hi = 8'h00; m_frame_q = 1'b0;
      for (int i = 0; i < 2; i++) begin
        m_n[i] = 0; m_cur[i] = 16'h0; m_rem[i] = 0;
        m_pv[i] = 1'b0; m_pend[i] = 16'h0; m_ov[i] = 1'b0;
      end
    end else begin
      m_dopush = 1'b0;
      m_pw = 16'h0;
      if (m_frame_q && !rx_frame) m_ph = 1'b0;
      else if (rx_strobe && rx_frame) begin
        if (!m_ph) begin m_hi = rx_data; m_ph = 1'b1; end
        else begin m_dopush = 1'b1; m_pw = {m_hi, rx_data}; m_ph = 1'b0; end
      end
      m_frame_q = rx_frame;
      for (int i = 0; i < 2; i++) begin
        m_pre = m_n[i];
        if (m_rem[i] > 1) m_rem[i]--;
        else if (m_pv[i]) begin
          m_cur[i] = m_pend[i]; m_pv[i] = 1'b0; m_rem[i] = hold_of(i) + 1;
        end else if (m_n[i] > 0) begin
          m_w = m_q[i][0];
          for (int k = 0; k < 15; k++) m_q[i][k] = m_q[i][k+1];
          m_n[i]--;
          if (m_w != m_cur[i]) begin
            m_cur[i] = m_w; m_rem[i] = hold_of(i) + 1;
          end else if (m_w != 16'h0) begin
            m_cur[i] = 16'h0; m_pend[i] = m_w; m_pv[i] = 1'b1;
            m_rem[i] = hold_of(i) + 1;
          end else m_rem[i] = 0;
        end else m_rem[i] = 0;
        if (m_dopush) begin
          if (m_pre == depth_of(i)) m_ov[i] = 1'b1;
          else begin m_q[i][m_n[i]] = m_pw; m_n[i]++; end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic cmp_inst(input int i, input logic [15:0] osd, input logic bsy,
                          input logic full, input logic ovf);
    string p;
    p = (i == 0) ? "A" : "B";
    check($sformatf("%s.osd_command", p), 32'(osd), 32'(m_cur[i]));
    check($sformatf("%s.busy", p), 32'(bsy),
          32'((m_n[i] != 0) || (m_rem[i] > 1) || m_pv[i]));
    check($sformatf("%s.fifo_full", p), 32'(full), 32'(m_n[i] == depth_of(i)));
    check($sformatf("%s.overflow", p), 32'(ovf), 32'(m_ov[i]));
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      cmp_inst(0, osd_a, busy_a, full_a, ovf_a);
      cmp_inst(1, osd_b, busy_b, full_b, ovf_b);
    end
  endtask

  // Output log of instance A, used to check run lengths of each value.
  logic [15:0] log_v [64];
  int          log_n;
  logic        log_en;

  task automatic log_loop();
    forever begin
      @(negedge clk);
      if (!log_en) log_n = 0;
      else if (log_n < 64) begin log_v[log_n] = osd_a; log_n++; end
    end
  endtask

  logic [15:0] rv [16];
  int          rl [16];
  int          nr;

  task automatic compress(input int n);
    nr = 0;
    for (int k = 0; k < n; k++) begin
      if (nr == 0 || log_v[k] != rv[nr-1]) begin
        if (nr < 16) begin rv[nr] = log_v[k]; rl[nr] = 1; nr++; end
      end else rl[nr-1]++;
    end
  endtask

  task automatic strobe(input logic [7:0] b);
    rx_data = b; rx_strobe = 1'b1;
    @(posedge clk); #1;
    rx_strobe = 1'b0;
  endtask

  task automatic frame_on();
    rx_frame = 1'b1; @(posedge clk); #1;
  endtask

  task automatic frame_off();
    rx_frame = 1'b0; @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (!busy_a && !busy_b) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL idle_wait: busy still high after 3000 cycles");
    end
    @(posedge clk); #1;
  endtask

  int bc;
  bit brun;

  initial begin
    reset = 1'b1; rx_data = 8'h00; rx_strobe = 1'b0; rx_frame = 1'b0;
    log_en = 1'b0; log_n = 0;
    fork
      compare_loop();
      log_loop();
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_osd", 32'(osd_a), 32'h0);
    check("rst_busy", 32'(busy_a), 32'h0);
    check("rst_full", 32'(full_a), 32'h0);
    check("rst_ovf", 32'(ovf_a), 32'h0);
    @(posedge clk); #1 reset = 1'b0;

    // Zero word against a zero output is discarded, then 0x0200 is shown
    frame_on();
    strobe(8'h00); strobe(8'h00);
    @(negedge clk); check("zero_busy_q", 32'(busy_a), 32'h1);
    @(negedge clk); check("zero_busy_done", 32'(busy_a), 32'h0);
    check("zero_osd", 32'(osd_a), 32'h0);
    @(posedge clk); #1;
    strobe(8'h02); strobe(8'h00);
    @(negedge clk);
    @(negedge clk);
    check("w0200_a", 32'(osd_a), 32'h0200);
    check("w0200_b", 32'(osd_b), 32'h0200);
    @(posedge clk); #1;
    frame_off();
    wait_idle();

    // Single pair: latency 1, busy for HOLD+1 cycles
    frame_on();
    strobe(8'h10); strobe(8'h05);
    bc = 0; brun = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k == 0) check("pair_before", 32'(osd_a), 32'h0200);
      if (k == 1) check("pair_latency", 32'(osd_a), 32'h1005);
      if (busy_a && brun) bc++; else brun = 1'b0;
    end
    check("pair_busy_len", 32'(bc), 32'd5);
    @(posedge clk); #1;
    frame_off();
    wait_idle();

    // Identical repeat: word, separator, word
    log_en = 1'b1;
    frame_on();
    strobe(8'h21); strobe(8'hAA); strobe(8'h21); strobe(8'hAA);
    frame_off();
    while (log_n < 40) @(negedge clk);
    compress(log_n);
    log_en = 1'b0;
    check("rep_runs", 32'(nr), 32'd4);
    check("rep_v1", 32'(rv[1]), 32'h21AA);
    check("rep_l1", 32'(rl[1]), 32'd5);
    check("rep_v2", 32'(rv[2]), 32'h0000);
    check("rep_l2", 32'(rl[2]), 32'd5);
    check("rep_v3", 32'(rv[3]), 32'h21AA);
    @(posedge clk); #1;
    wait_idle();

    // Odd byte dropped at frame end
    log_en = 1'b1;
    @(posedge clk); #1;
    frame_on();
    strobe(8'h13); strobe(8'h07); strobe(8'h12);
    frame_off();
    frame_on();
    strobe(8'h01); strobe(8'h01);
    frame_off();
    while (log_n < 40) @(negedge clk);
    compress(log_n);
    log_en = 1'b0;
    check("odd_runs", 32'(nr), 32'd3);
    check("odd_v1", 32'(rv[1]), 32'h1307);
    check("odd_v2", 32'(rv[2]), 32'h0101);
    @(posedge clk); #1;
    wait_idle();

    // Overflow on the shallow instance
    frame_on();
    for (int k = 1; k <= 6; k++) begin
      strobe(8'h30); strobe(8'(k));
    end
    @(negedge clk);
    check("ovf_full_b", 32'(full_b), 32'h1);
    check("ovf_flag_b", 32'(ovf_b), 32'h1);
    check("ovf_flag_a", 32'(ovf_a), 32'h0);
    @(posedge clk); #1;
    frame_off();
    wait_idle();
    check("ovf_sticky_b", 32'(ovf_b), 32'h1);
    check("ovf_drained_b", 32'(full_b), 32'h0);
    check("ovf_last_b", 32'(osd_b), 32'h3005);
    check("ovf_last_a", 32'(osd_a), 32'h3006);

    // Reset during a separator with three words queued
    frame_on();
    strobe(8'h44); strobe(8'h44); strobe(8'h44); strobe(8'h44);
    strobe(8'h45); strobe(8'h01); strobe(8'h45); strobe(8'h02);
    strobe(8'h45); strobe(8'h03);
    @(negedge clk);
    check("sep_osd_a", 32'(osd_a), 32'h0);
    check("sep_busy_a", 32'(busy_a), 32'h1);
    check("sep_osd_b", 32'(osd_b), 32'h4444);
    #2;
    reset = 1'b1; rx_frame = 1'b0;
    #1;
    check("arst_osd_a", 32'(osd_a), 32'h0);
    check("arst_busy_a", 32'(busy_a), 32'h0);
    check("arst_osd_b", 32'(osd_b), 32'h0);
    check("arst_busy_b", 32'(busy_b), 32'h0);
    check("arst_ovf_b", 32'(ovf_b), 32'h0);
    @(posedge clk); #1 reset = 1'b0;
    frame_on();
    strobe(8'h55); strobe(8'h66);
    @(negedge clk);
    @(negedge clk);
    check("post_rst_a", 32'(osd_a), 32'h5566);
    check("post_rst_b", 32'(osd_b), 32'h5566);
    @(posedge clk); #1;
    frame_off();
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
